// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter: shares one SRAM-style bus between the fetch port and the
// load/store port. One transaction at a time, split address/data handshake,
// per-port done flags that hold while the pipeline is frozen.
module sram_bus_arbiter #(
    parameter int DATA_FIRST = 1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_rdata,
    output logic        inst_stall,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_stall,

    input  logic        pipe_stall,

    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        I_ADDR = 3'd1,
        I_WAIT = 3'd2,
        D_ADDR = 3'd3,
        D_WAIT = 3'd4
    } state_t;

    localparam logic DATA_WINS = (DATA_FIRST != 0);

    state_t      state_q,      state_d;
    logic        inst_done_q,  inst_done_d;
    logic        data_done_q,  data_done_d;
    logic        bus_req_q,    bus_req_d;
    logic        bus_wr_q,     bus_wr_d;
    logic [1:0]  bus_size_q,   bus_size_d;
    logic [31:0] bus_addr_q,   bus_addr_d;
    logic [31:0] bus_wdata_q,  bus_wdata_d;
    logic [31:0] inst_rdata_q, inst_rdata_d;
    logic [31:0] data_rdata_q, data_rdata_d;

    logic inst_pend;
    logic data_pend;
    logic grant_data;

    // Pending/grant decisions and the stall requests seen by the hazard unit
    assign inst_pend  = inst_req & ~inst_done_q;
    assign data_pend  = data_req & ~data_done_q;
    assign grant_data = data_pend & (DATA_WINS | ~inst_pend);

    assign inst_stall = inst_pend;
    assign data_stall = data_pend;

    assign bus_req    = bus_req_q;
    assign bus_wr     = bus_wr_q;
    assign bus_size   = bus_size_q;
    assign bus_addr   = bus_addr_q;
    assign bus_wdata  = bus_wdata_q;
    assign inst_rdata = inst_rdata_q;
    assign data_rdata = data_rdata_q;

    // Next-state logic: grant in IDLE, walk the handshake, capture on completion
    always_comb begin
        state_d      = state_q;
        inst_done_d  = inst_done_q;
        data_done_d  = data_done_q;
        bus_req_d    = bus_req_q;
        bus_wr_d     = bus_wr_q;
        bus_size_d   = bus_size_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;

        // A moving pipeline consumes both results; setting below overrides this.
        if (!pipe_stall) begin
            inst_done_d = 1'b0;
            data_done_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (grant_data) begin
                    state_d     = D_ADDR;
                    bus_req_d   = 1'b1;
                    bus_wr_d    = data_wr;
                    bus_size_d  = data_size;
                    bus_addr_d  = data_addr;
                    bus_wdata_d = data_wdata;
                end else if (inst_pend) begin
                    // Fetches are always word reads; no write data to carry.
                    state_d     = I_ADDR;
                    bus_req_d   = 1'b1;
                    bus_wr_d    = 1'b0;
                    bus_size_d  = 2'd2;
                    bus_addr_d  = inst_addr;
                    bus_wdata_d = 32'h0;
                end
            end
            I_ADDR: begin
                if (bus_addr_ok) begin
                    bus_req_d = 1'b0;
                    if (bus_data_ok) begin
                        state_d      = IDLE;
                        inst_rdata_d = bus_rdata;
                        inst_done_d  = 1'b1;
                    end else begin
                        state_d = I_WAIT;
                    end
                end
            end
            I_WAIT: begin
                if (bus_data_ok) begin
                    state_d      = IDLE;
                    inst_rdata_d = bus_rdata;
                    inst_done_d  = 1'b1;
                end
            end
            D_ADDR: begin
                if (bus_addr_ok) begin
                    bus_req_d = 1'b0;
                    if (bus_data_ok) begin
                        state_d      = IDLE;
                        data_rdata_d = bus_rdata;
                        data_done_d  = 1'b1;
                    end else begin
                        state_d = D_WAIT;
                    end
                end
            end
            D_WAIT: begin
                if (bus_data_ok) begin
                    state_d      = IDLE;
                    data_rdata_d = bus_rdata;
                    data_done_d  = 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                bus_req_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset abandons any transaction in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            inst_done_q  <= 1'b0;
            data_done_q  <= 1'b0;
            bus_req_q    <= 1'b0;
            bus_wr_q     <= 1'b0;
            bus_size_q   <= 2'd0;
            bus_addr_q   <= 32'h0;
            bus_wdata_q  <= 32'h0;
            inst_rdata_q <= 32'h0;
            data_rdata_q <= 32'h0;
        end else begin
            state_q      <= state_d;
            inst_done_q  <= inst_done_d;
            data_done_q  <= data_done_d;
            bus_req_q    <= bus_req_d;
            bus_wr_q     <= bus_wr_d;
            bus_size_q   <= bus_size_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
        end
    end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// tb_sram_bus_arbiter: scenario tasks with a scoreboard of expected bus
// transactions; a small slave responder drives addr_ok/data_ok timing.
module tb_sram_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_stall;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_stall;
    logic        pipe_stall;
    logic        bus_req;
    logic        bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    txn_t exp_q[$];
    int   compared   = 0;
    int   mismatched = 0;

    sram_bus_arbiter #(.DATA_FIRST(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .inst_req   (inst_req),
        .inst_addr  (inst_addr),
        .inst_rdata (inst_rdata),
        .inst_stall (inst_stall),
        .data_req   (data_req),
        .data_wr    (data_wr),
        .data_size  (data_size),
        .data_addr  (data_addr),
        .data_wdata (data_wdata),
        .data_rdata (data_rdata),
        .data_stall (data_stall),
        .pipe_stall (pipe_stall),
        .bus_req    (bus_req),
        .bus_wr     (bus_wr),
        .bus_size   (bus_size),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_addr_ok(bus_addr_ok),
        .bus_data_ok(bus_data_ok),
        .bus_rdata  (bus_rdata)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Hard stop in case something hangs outside the bounded waits
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Advance to the next cycle; all driving and sampling happens 2 time units after the edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Bus slave: waits for bus_req, holds addr_ok low for aw cycles, then gives
    // data_ok dw cycles after addr_ok (dw=0 means same cycle). Reports what it saw.
    task automatic serve(input int aw, input int dw, input logic [31:0] rd, input bit scramble,
                         output txn_t obs, output int wait_n, output int req_n,
                         output bit stable, output bit timeout);
        txn_t cur;
        wait_n  = 0;
        req_n   = 0;
        stable  = 1'b1;
        timeout = 1'b0;
        obs     = '0;
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        bus_rdata   = 32'hBAD0_BAD0;
        while (!bus_req && wait_n < 20) begin
            tick();
            wait_n++;
        end
        if (!bus_req) begin
            timeout = 1'b1;
            return;
        end
        obs = {bus_wr, bus_size, bus_addr, bus_wdata};
        if (scramble) begin
            inst_req   = 1'b0;
            inst_addr  = ~inst_addr;
            data_addr  = ~data_addr;
            data_wdata = ~data_wdata;
            data_size  = ~data_size;
            data_wr    = ~data_wr;
        end
        for (int k = 0; k < aw; k++) begin
            if (bus_req) req_n++;
            tick();
            cur = {bus_wr, bus_size, bus_addr, bus_wdata};
            if (cur !== obs) stable = 1'b0;
        end
        if (bus_req) req_n++;
        bus_addr_ok = 1'b1;
        if (dw == 0) begin
            bus_data_ok = 1'b1;
            bus_rdata   = rd;
        end
        tick();
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        bus_rdata   = 32'hBAD0_BAD0;
        if (dw > 0) begin
            for (int k = 1; k < dw; k++) begin
                cur = {bus_wr, bus_size, bus_addr, bus_wdata};
                if (cur !== obs) stable = 1'b0;
                if (bus_req) req_n++;
                tick();
            end
            cur = {bus_wr, bus_size, bus_addr, bus_wdata};
            if (cur !== obs) stable = 1'b0;
            if (bus_req) req_n++;
            bus_data_ok = 1'b1;
            bus_rdata   = rd;
            tick();
            bus_data_ok = 1'b0;
            bus_rdata   = 32'hBAD0_BAD0;
        end
    endtask

    // Let the pipeline advance and drop both requests
    task automatic release_pipe();
        pipe_stall = 1'b0;
        inst_req   = 1'b0;
        data_req   = 1'b0;
        tick();
    endtask

    // Reset values and stall = req right after reset
    task automatic test_reset();
        rst = 1'b1; inst_req = 1'b1; data_req = 1'b1; pipe_stall = 1'b0;
        inst_addr = 32'h1234_5678; data_wr = 1'b1; data_size = 2'd1;
        data_addr = 32'h8765_4321; data_wdata = 32'hFFFF_0000;
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'hBAD0_BAD0;
        tick(); tick();
        compared++;
        if ({bus_req, bus_wr, bus_size} !== 4'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_ctrl: got %b expected 0000", {bus_req, bus_wr, bus_size});
        end
        compared++;
        if ({bus_addr, bus_wdata} !== 64'h0) begin
            mismatched++;
            $display("[TB] FAIL reset_bus_fields: got %h expected 0", {bus_addr, bus_wdata});
        end
        compared++;
        if ({inst_rdata, data_rdata} !== 64'h0) begin
            mismatched++;
            $display("[TB] FAIL reset_rdata: got %h expected 0", {inst_rdata, data_rdata});
        end
        rst = 1'b0;
        #1;
        compared++;
        if ({inst_stall, data_stall} !== 2'b11) begin
            mismatched++;
            $display("[TB] FAIL reset_stall_eq_req: got %b expected 11", {inst_stall, data_stall});
        end
        inst_req = 1'b0; data_req = 1'b0;
        tick(); tick();
        compared++;
        if (bus_req !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_idle_no_req: got %b expected 0", bus_req);
        end
    endtask

    // Single fetch: addr_ok in cycle 1, data_ok in cycle 2
    task automatic test_fetch();
        txn_t obs, e;
        int wait_n, req_n;
        bit stable, to;
        pipe_stall = 1'b1;
        inst_req = 1'b1; inst_addr = 32'hBFC0_0000; data_wdata = 32'hCAFE_F00D;
        exp_q.push_back({1'b0, 2'd2, 32'hBFC0_0000, 32'h0});
        serve(0, 1, 32'h2408_0001, 1'b0, obs, wait_n, req_n, stable, to);
        compared++;
        if (to !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL fetch_timeout: got %b expected 0", to);
        end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        compared++;
        if (obs !== e) begin
            mismatched++;
            $display("[TB] FAIL fetch_txn: got %h expected %h", obs, e);
        end
        compared++;
        if (wait_n !== 1 || req_n !== 1) begin
            mismatched++;
            $display("[TB] FAIL fetch_timing: got wait=%0d req=%0d expected wait=1 req=1", wait_n, req_n);
        end
        compared++;
        if (inst_rdata !== 32'h2408_0001 || inst_stall !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL fetch_result: got %h stall=%b expected 24080001 stall=0", inst_rdata, inst_stall);
        end
        release_pipe();
    endtask

    // Load and fetch together: load goes first, fetch follows, no reissue while frozen
    task automatic test_priority();
        txn_t obs, e;
        int wait_n, req_n, extra;
        bit stable, to;
        pipe_stall = 1'b1;
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2;
        data_addr = 32'h8000_1000; data_wdata = 32'h1111_2222;
        inst_req = 1'b1; inst_addr = 32'hBFC0_0004;
        exp_q.push_back({1'b0, 2'd2, 32'h8000_1000, 32'h1111_2222});
        exp_q.push_back({1'b0, 2'd2, 32'hBFC0_0004, 32'h0});
        serve(2, 2, 32'hDEAD_BEEF, 1'b0, obs, wait_n, req_n, stable, to);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        compared++;
        if (to !== 1'b0 || obs !== e) begin
            mismatched++;
            $display("[TB] FAIL prio_first_txn: got %h to=%b expected %h", obs, to, e);
        end
        compared++;
        if (req_n !== 3 || stable !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL prio_first_hold: got req=%0d stable=%b expected req=3 stable=1", req_n, stable);
        end
        compared++;
        if ({data_stall, inst_stall} !== 2'b01 || data_rdata !== 32'hDEAD_BEEF) begin
            mismatched++;
            $display("[TB] FAIL prio_after_load: got stalls=%b rdata=%h expected 01 deadbeef", {data_stall, inst_stall}, data_rdata);
        end
        serve(1, 1, 32'h3C1D_0000, 1'b0, obs, wait_n, req_n, stable, to);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        compared++;
        if (to !== 1'b0 || obs !== e) begin
            mismatched++;
            $display("[TB] FAIL prio_second_txn: got %h to=%b expected %h", obs, to, e);
        end
        extra = 0;
        for (int k = 0; k < 3; k++) begin
            if (bus_req) extra++;
            if (data_stall) extra++;
            tick();
        end
        compared++;
        if (extra !== 0 || inst_rdata !== 32'h3C1D_0000) begin
            mismatched++;
            $display("[TB] FAIL prio_frozen_no_reissue: got extra=%0d irdata=%h expected 0 3c1d0000", extra, inst_rdata);
        end
        release_pipe();
    endtask

    // Byte store with addr_ok held off 3 cycles and inputs changing mid-flight
    task automatic test_store();
        txn_t obs, e;
        int wait_n, req_n, extra;
        bit stable, to;
        pipe_stall = 1'b1;
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd0;
        data_addr = 32'h8000_0003; data_wdata = 32'h0000_00AB;
        exp_q.push_back({1'b1, 2'd0, 32'h8000_0003, 32'h0000_00AB});
        serve(3, 0, 32'h5A5A_0000, 1'b1, obs, wait_n, req_n, stable, to);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        compared++;
        if (to !== 1'b0 || obs !== e) begin
            mismatched++;
            $display("[TB] FAIL store_txn: got %h to=%b expected %h", obs, to, e);
        end
        compared++;
        if (req_n !== 4 || stable !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL store_stable: got req=%0d stable=%b expected req=4 stable=1", req_n, stable);
        end
        compared++;
        if (data_rdata !== 32'h5A5A_0000 || data_stall !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL store_done: got rdata=%h stall=%b expected 5a5a0000 0", data_rdata, data_stall);
        end
        extra = 0;
        for (int k = 0; k < 3; k++) begin
            if (bus_req) extra++;
            tick();
        end
        compared++;
        if (extra !== 0) begin
            mismatched++;
            $display("[TB] FAIL store_single: got extra=%0d expected 0", extra);
        end
        release_pipe();
    endtask

    // Same-cycle addr_ok/data_ok on a load, then the fetch granted after exactly one IDLE cycle
    task automatic test_back_to_back();
        txn_t obs, e;
        int wait_n, req_n;
        bit stable, to;
        pipe_stall = 1'b1;
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd1;
        data_addr = 32'h8000_2002; data_wdata = 32'h0;
        inst_req = 1'b1; inst_addr = 32'hBFC0_0008;
        exp_q.push_back({1'b0, 2'd1, 32'h8000_2002, 32'h0});
        exp_q.push_back({1'b0, 2'd2, 32'hBFC0_0008, 32'h0});
        serve(0, 0, 32'h0000_7777, 1'b0, obs, wait_n, req_n, stable, to);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        compared++;
        if (to !== 1'b0 || obs !== e || wait_n !== 1) begin
            mismatched++;
            $display("[TB] FAIL b2b_load_txn: got %h wait=%0d expected %h wait=1", obs, wait_n, e);
        end
        compared++;
        if (data_stall !== 1'b0 || data_rdata !== 32'h0000_7777 || bus_req !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL b2b_same_cycle: got stall=%b rdata=%h req=%b expected 0 00007777 0", data_stall, data_rdata, bus_req);
        end
        serve(0, 0, 32'h8FA8_0010, 1'b0, obs, wait_n, req_n, stable, to);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        compared++;
        if (to !== 1'b0 || obs !== e || wait_n !== 1) begin
            mismatched++;
            $display("[TB] FAIL b2b_fetch_txn: got %h wait=%0d expected %h wait=1", obs, wait_n, e);
        end
        compared++;
        if (inst_stall !== 1'b0 || inst_rdata !== 32'h8FA8_0010) begin
            mismatched++;
            $display("[TB] FAIL b2b_fetch_done: got stall=%b rdata=%h expected 0 8fa80010", inst_stall, inst_rdata);
        end
        release_pipe();
    endtask

    // Fetch whose request drops mid-transaction still completes
    task automatic test_req_drop();
        txn_t obs, e;
        int wait_n, req_n, extra;
        bit stable, to;
        pipe_stall = 1'b1;
        inst_req = 1'b1; inst_addr = 32'hBFC0_0010;
        exp_q.push_back({1'b0, 2'd2, 32'hBFC0_0010, 32'h0});
        serve(1, 2, 32'h1234_ABCD, 1'b1, obs, wait_n, req_n, stable, to);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        compared++;
        if (to !== 1'b0 || obs !== e || stable !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL drop_txn: got %h stable=%b expected %h stable=1", obs, stable, e);
        end
        extra = 0;
        for (int k = 0; k < 2; k++) begin
            if (bus_req) extra++;
            tick();
        end
        compared++;
        if (inst_rdata !== 32'h1234_ABCD || inst_stall !== 1'b0 || extra !== 0) begin
            mismatched++;
            $display("[TB] FAIL drop_done: got rdata=%h stall=%b extra=%0d expected 1234abcd 0 0", inst_rdata, inst_stall, extra);
        end
        release_pipe();
    endtask

    // Reset while waiting for fetch data abandons it; a fresh fetch then issues
    task automatic test_reset_mid();
        txn_t obs, e;
        int wait_n, req_n, n;
        bit stable, to;
        pipe_stall = 1'b1;
        inst_req = 1'b1; inst_addr = 32'hBFC0_0020;
        n = 0;
        while (!bus_req && n < 20) begin
            tick();
            n++;
        end
        compared++;
        if (bus_req !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL rstmid_grant: got %b expected 1", bus_req);
        end
        bus_addr_ok = 1'b1;
        tick();
        bus_addr_ok = 1'b0;
        rst = 1'b1;
        tick();
        compared++;
        if (bus_req !== 1'b0 || inst_rdata !== 32'h0 || data_rdata !== 32'h0 || inst_stall !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL rstmid_state: got req=%b irdata=%h drdata=%h istall=%b expected 0 0 0 1", bus_req, inst_rdata, data_rdata, inst_stall);
        end
        rst = 1'b0;
        exp_q.push_back({1'b0, 2'd2, 32'hBFC0_0020, 32'h0});
        serve(0, 0, 32'h0BAD_CAFE, 1'b0, obs, wait_n, req_n, stable, to);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        compared++;
        if (to !== 1'b0 || obs !== e || wait_n !== 1) begin
            mismatched++;
            $display("[TB] FAIL rstmid_refetch: got %h wait=%0d to=%b expected %h wait=1", obs, wait_n, to, e);
        end
        compared++;
        if (inst_rdata !== 32'h0BAD_CAFE) begin
            mismatched++;
            $display("[TB] FAIL rstmid_rdata: got %h expected 0badcafe", inst_rdata);
        end
        release_pipe();
    endtask

    // Run every scenario in order, then report
    initial begin
        test_reset();
        test_fetch();
        test_priority();
        test_store();
        test_back_to_back();
        test_req_drop();
        test_reset_mid();
        compared++;
        if (exp_q.size() !== 0) begin
            mismatched++;
            $display("[TB] FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/sram_bus_arbiter.md
SRAM_BUS_ARBITER -- requirements
Module: sram_bus_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_FIRST, default 1; when 1, the data port wins simultaneous requests, and when 0, the inst port wins.
REQ-002 The block SHALL have clock port clk, input, 1 bit: the single clock, rising edge.
REQ-003 The block SHALL have reset port rst, input, 1 bit: reset is synchronous and active-high.
REQ-004 The block SHALL have port inst_req, input, 1 bit: instruction fetch request, level, held until serviced.
REQ-005 The block SHALL have port inst_addr, input, 32 bits: fetch address, word aligned.
REQ-006 The block SHALL have port inst_rdata, output, 32 bits: registered fetch result.
REQ-007 The block SHALL have port inst_stall, output, 1 bit: the fetch stall request to the hazard unit (stallreq_from_if).
REQ-008 The block SHALL have port data_req, input, 1 bit: load/store request, level.
REQ-009 The block SHALL have port data_wr, input, 1 bit: 1 = store, 0 = load.
REQ-010 The block SHALL have port data_size, input, 2 bits: 0 = byte, 1 = half, 2 = word.
REQ-011 The block SHALL have port data_addr, input, 32 bits: data address.
REQ-012 The block SHALL have port data_wdata, input, 32 bits: store data.
REQ-013 The block SHALL have port data_rdata, output, 32 bits: registered load result.
REQ-014 The block SHALL have port data_stall, output, 1 bit: the data stall request to the hazard unit (stallreq_from_mem).
REQ-015 The block SHALL have port pipe_stall, input, 1 bit: global pipeline freeze (the OR of all stall sources).
REQ-016 The block SHALL have port bus_req, output, 1 bit: downstream request.
REQ-017 The block SHALL have port bus_wr, output, 1 bit: downstream write.
REQ-018 The block SHALL have port bus_size, output, 2 bits: downstream size.
REQ-019 The block SHALL have port bus_addr, output, 32 bits: downstream address.
REQ-020 The block SHALL have port bus_wdata, output, 32 bits: downstream write data.
REQ-021 The block SHALL have port bus_addr_ok, input, 1 bit: address accepted, valid only while bus_req=1.
REQ-022 The block SHALL have port bus_data_ok, input, 1 bit: transaction complete; bus_rdata is valid in the same cycle.
REQ-023 The block SHALL have port bus_rdata, input, 32 bits: downstream read data.

Function
REQ-024 The FSM SHALL have states IDLE, I_ADDR, I_WAIT, D_ADDR and D_WAIT, encoded in a 3-bit register.
REQ-025 A port SHALL be pending when its req=1 and its done flag=0.
REQ-026 In IDLE, on the clock edge: if any port is pending, the FSM SHALL grant one port per DATA_FIRST, latch the granted addr/wr/size/wdata into bus registers, and enter I_ADDR or D_ADDR; otherwise it SHALL stay in IDLE.
REQ-027 For an inst grant, bus_wr=0 and bus_size=2 SHALL be forced.
REQ-028 bus_req SHALL be 1 only in I_ADDR and D_ADDR.
REQ-029 bus_wr, bus_size, bus_addr and bus_wdata SHALL be driven from the latched registers and SHALL be stable for the whole transaction.
REQ-030 In X_ADDR, addr_ok=1 with data_ok=0 SHALL move the FSM to X_WAIT.
REQ-031 In X_ADDR, addr_ok=1 with data_ok=1 SHALL complete the transaction in the same cycle and return to IDLE.
REQ-032 In X_ADDR, addr_ok=0 SHALL hold the state.
REQ-033 In X_WAIT, data_ok=1 SHALL complete the transaction and return to IDLE; data_ok=0 SHALL hold the state.
REQ-034 On completion, bus_rdata SHALL be captured into the granted port's rdata register for both loads and stores, and that port's done flag SHALL be set.
REQ-035 inst_stall SHALL equal inst_req & ~inst_done, and data_stall SHALL equal data_req & ~data_done; both are combinational from registers and inputs, and neither depends on pipe_stall.
REQ-036 Both done flags SHALL be cleared on any clock edge where pipe_stall=0, so a finished port is not reissued while the pipeline is frozen by the other port.
REQ-037 Clearing a done flag SHALL take priority below setting it in the same cycle.
REQ-038 An issued transaction SHALL never be cancelled; changes to req, addr or pipe_stall mid-transaction SHALL NOT affect bus outputs.
REQ-039 A port whose req drops mid-transaction SHALL still receive its completion: done is set, and its stall output is 0 because req=0.
REQ-040 The minimum latency from request to stall low SHALL be 2 cycles plus the bus latency: request seen in IDLE at edge 0; bus_req in cycle 1; with addr_ok and data_ok both in cycle 1, stall is low in cycle 2.
REQ-041 After each completion the FSM SHALL return to IDLE for at least one cycle; there are no back-to-back grants.
REQ-042 With both ports pending, the granted port SHALL be serviced first and the other port granted on the next IDLE edge.

Reset
REQ-043 When rst=1 at the clock edge: state SHALL go to IDLE; both done flags, bus_req, bus_wr, bus_size, bus_addr, bus_wdata, inst_rdata and data_rdata SHALL be 0.
REQ-044 Reset mid-transaction SHALL abandon the transaction, on the basis that the downstream slave shares rst.
REQ-045 In the first cycle after reset, the stall outputs SHALL equal the req inputs.

Verification
REQ-046 Fetch only: inst_req=1, inst_addr=0xBFC00000; addr_ok in cycle 1, data_ok in cycle 2 with rdata=0x24080001 -> bus_req=1 in cycle 1 only, inst_rdata=0x24080001, inst_stall=0 from cycle 3.
REQ-047 Simultaneous requests with DATA_FIRST=1: load from 0x80001000 and fetch from 0xBFC00004 -> data transaction issues first and inst is issued only after data completes; with pipe_stall=1, data_done holds, no second data transaction occurs, and data_stall stays 0.
REQ-048 Store: data_wr=1, size=0, addr=0x80000003, wdata=0x000000AB; addr_ok held 0 for 3 cycles -> bus_req and latched fields stable for 4 cycles, then one store is seen.
REQ-049 Same-cycle addr_ok and data_ok in D_ADDR -> capture and return to IDLE without visiting D_WAIT.
REQ-050 Reset asserted in I_WAIT -> next cycle: IDLE, bus_req=0, inst_rdata=0, done flags=0.
